ysyx_22040759_lsu: RTL and testbench

Load/store unit between the core's ALU/operand stage and the data memory bus. Registers one load or store request (address from ALU result, store data from rs2). Performs the valid/ready transaction on a 64-bit doubleword-aligned memory port. Returns the aligned, sign- or zero-extended load data to the register write-back mux, and holds `busy` to stall PC update while an access is in flight.

---
 rtl/ysyx_22040759_lsu_pkg.sv | 45 ++++
 rtl/ysyx_22040759_lsu_align.sv | 31 +++
 rtl/ysyx_22040759_lsu.sv | 142 ++++++++++++++
 tb/tb_ysyx_22040759_lsu.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040759_lsu_pkg.sv
// Shared encodings for the ysyx_22040759 load/store unit: access sizes, FSM states, size masks.
package ysyx_22040759_lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } lsu_size_e;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StResp
  } lsu_state_e;

  localparam logic [7:0] MaskB = 8'h01;
  localparam logic [7:0] MaskH = 8'h03;
  localparam logic [7:0] MaskW = 8'h0F;
  localparam logic [7:0] MaskD = 8'hFF;

  function automatic logic [7:0] size_mask(lsu_size_e size);
    logic [7:0] mask;
    unique case (size)
      SZ_B: mask = MaskB;
      SZ_H: mask = MaskH;
      SZ_W: mask = MaskW;
      SZ_D: mask = MaskD;
    endcase
    return mask;
  endfunction

  function automatic logic is_misaligned(lsu_size_e size, logic [2:0] off);
    logic mis;
    unique case (size)
      SZ_B: mis = 1'b0;
      SZ_H: mis = off[0];
      SZ_W: mis = |off[1:0];
      SZ_D: mis = |off;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/ysyx_22040759_lsu_align.sv
// Combinational lane logic: store strobe/data shift into the doubleword, load shift and extend.
module ysyx_22040759_lsu_align
  import ysyx_22040759_lsu_pkg::*;
(
  input  lsu_size_e   size,
  input  logic        is_unsigned,
  input  logic [2:0]  off,
  input  logic [63:0] st_data,
  input  logic [63:0] ld_raw,
  output logic [7:0]  st_strb,
  output logic [63:0] st_data_sh,
  output logic [63:0] ld_data
);

  logic [63:0] ld_sh;

  // Shifts truncate naturally, so lanes past the doubleword boundary are dropped.
  always_comb begin
    st_strb    = size_mask(size) << off;
    st_data_sh = st_data << {off, 3'b000};
    ld_sh      = ld_raw >> {off, 3'b000};
    ld_data    = '0;
    unique case (size)
      SZ_B: ld_data = {{56{ld_sh[7] & ~is_unsigned}}, ld_sh[7:0]};
      SZ_H: ld_data = {{48{ld_sh[15] & ~is_unsigned}}, ld_sh[15:0]};
      SZ_W: ld_data = {{32{ld_sh[31] & ~is_unsigned}}, ld_sh[31:0]};
      SZ_D: ld_data = ld_sh;
    endcase
  end

endmodule

// File: rtl/ysyx_22040759_lsu.sv
// Load/store unit: one registered request, valid/ready doubleword bus access with timeout.
// Optional misalignment trap enabled by defining YSYX_22040759_LSU_MISALIGN_CHK_EN.
module ysyx_22040759_lsu
  import ysyx_22040759_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        busy,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [63:0] mem_addr,
  output logic        mem_wen,
  output logic [7:0]  mem_wstrb,
  output logic [63:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata
);

  lsu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [63:0]      rdata_q, rdata_d;
  logic [63:0]      addr_q, wdata_q;
  logic             wen_q, uns_q;
  lsu_size_e        size_q;

  logic        accept, timeout_hit;
  logic [7:0]  st_strb;
  logic [63:0] st_data_sh, ld_data;

  assign accept      = req_valid & (state_q == StIdle);
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  ysyx_22040759_lsu_align u_align (
    .size        (size_q),
    .is_unsigned (uns_q),
    .off         (addr_q[2:0]),
    .st_data     (wdata_q),
    .ld_raw      (mem_rdata),
    .st_strb     (st_strb),
    .st_data_sh  (st_data_sh),
    .ld_data     (ld_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    err_d   = err_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StReq;
          err_d   = 1'b0;
          rdata_d = '0;
`ifdef YSYX_22040759_LSU_MISALIGN_CHK_EN
          if (is_misaligned(lsu_size_e'(req_size), req_addr[2:0])) begin
            state_d = StResp;
            err_d   = 1'b1;
          end
`endif
        end
      end
      StReq: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_ready && mem_rvalid) begin
          state_d = StResp;
          rdata_d = wen_q ? '0 : ld_data;
        end else if (timeout_hit) begin
          state_d = StResp;
          err_d   = 1'b1;
        end else if (mem_ready) begin
          state_d = StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_rvalid) begin
          state_d = StResp;
          rdata_d = wen_q ? '0 : ld_data;
        end else if (timeout_hit) begin
          state_d = StResp;
          err_d   = 1'b1;
        end
      end
      StResp: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= SZ_B;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wen_q   <= req_wen;
        uns_q   <= req_unsigned;
        size_q  <= lsu_size_e'(req_size);
      end
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign busy       = (state_q != StIdle) | req_valid;
  assign resp_valid = (state_q == StResp);
  assign resp_err   = resp_valid & err_q;
  assign resp_rdata = rdata_q;

  // Bus fields are gated so they read as zero whenever no request is presented.
  assign mem_valid = (state_q == StReq);
  assign mem_addr  = mem_valid ? {addr_q[63:3], 3'b000} : '0;
  assign mem_wen   = mem_valid & wen_q;
  assign mem_wstrb = mem_valid ? st_strb : '0;
  assign mem_wdata = mem_valid ? st_data_sh : '0;

endmodule

// File: tb/tb_ysyx_22040759_lsu.sv
// Randomized bench for ysyx_22040759_lsu against a byte-level reference model.
module tb_ysyx_22040759_lsu;

  localparam int unsigned TIMEOUT = 255;
  localparam int unsigned CNT_W   = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, busy;
  logic [63:0] resp_rdata;
  logic        mem_valid, mem_ready, mem_wen, mem_rvalid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wstrb;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ysyx_22040759_lsu #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wen      (req_wen),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .busy         (busy),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_addr     (mem_addr),
    .mem_wen      (mem_wen),
    .mem_wstrb    (mem_wstrb),
    .mem_wdata    (mem_wdata),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: byte-lane arithmetic straight from the access rules.
  function automatic logic [63:0] model_load(logic [63:0] dw, int n, bit uns, int off);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < n; i++)
      if (off + i < 8) v = v | (64'(dw[8*(off+i) +: 8]) << (8 * i));
    if (!uns && n < 8 && v[8*n-1]) v = v - (64'd1 << (8 * n));
    return v;
  endfunction

  function automatic logic [7:0] model_strb(int n, int off);
    logic [7:0] s;
    s = '0;
    for (int i = 0; i < n; i++)
      if (off + i < 8) s[off+i] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] model_wdata(logic [63:0] wd, int off);
    logic [63:0] w;
    w = '0;
    for (int b = 0; b < 8; b++)
      if (b >= off) w[8*b +: 8] = wd[8*(b-off) +: 8];
    return w;
  endfunction

  // rd: cycles of mem_ready low in REQ; rv: cycles from handshake to rvalid (<0 = never).
  task automatic do_access(input bit wen, input int n_log, input bit uns, input logic [63:0] addr,
                           input logic [63:0] wd, input logic [63:0] dw, input int rd,
                           input int rv);
    int          n, off, resp_cyc;
    bit          mis, exp_err, exp_mv;
    logic [63:0] exp_data;
    n   = 1 << n_log;
    off = int'(addr[2:0]);
    mis = 1'b0;
`ifdef YSYX_22040759_LSU_MISALIGN_CHK_EN
    mis = (off % n) != 0;
`endif
    exp_err  = mis || (rv < 0);
    exp_data = (exp_err || wen) ? 64'd0 : model_load(dw, n, uns, off);
    resp_cyc = mis ? 1 : (rv < 0) ? 1 + int'(TIMEOUT) : 2 + rd + rv;

    check_eq("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;  req_wen = wen;  req_size = 2'(n_log);  req_unsigned = uns;
    req_addr  = addr;  req_wdata = wd;
    #1;
    check_eq("accept_status", {busy, mem_valid, resp_valid}, 3'b100);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom};
    req_wen   = ~wen;
    for (int cyc = 1; cyc < resp_cyc; cyc++) begin
      exp_mv     = (cyc <= 1 + rd);
      mem_ready  = (cyc == 1 + rd);
      mem_rvalid = (rv >= 0) && (cyc == 1 + rd + rv);
      mem_rdata  = mem_rvalid ? dw : {$urandom, $urandom};
      #1;
      check_eq("status", {resp_valid, busy, req_ready, mem_valid}, {3'b010, exp_mv});
      if (exp_mv) begin
        check_eq("mem_addr", mem_addr, {addr[63:3], 3'b000});
        check_eq("mem_wen", mem_wen, wen);
        if (wen) begin
          check_eq("mem_wstrb", mem_wstrb, model_strb(n, off));
          check_eq("mem_wdata", mem_wdata, model_wdata(wd, off));
        end
      end
      @(posedge clk); #1;
    end
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    #1;
    check_eq("resp_status", {resp_valid, busy, req_ready, mem_valid}, 4'b1100);
    check_eq("resp_err", resp_err, exp_err);
    check_eq("resp_rdata", resp_rdata, exp_data);
    @(posedge clk); #1;
    check_eq("after_resp", {resp_valid, req_ready, resp_err}, 3'b010);
    check_eq("rdata_hold", resp_rdata, exp_data);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a;
    rst = 1'b0;  req_valid = 1'b0;  req_wen = 1'b0;  req_size = 2'd0;  req_unsigned = 1'b0;
    req_addr = '0;  req_wdata = '0;  mem_ready = 1'b0;  mem_rvalid = 1'b0;  mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_ready", req_ready, 1);
    check_eq("reset_ctrl", {resp_valid, resp_err, busy, mem_valid, mem_wen}, 5'b0);
    check_eq("reset_rdata", resp_rdata, 0);
    check_eq("reset_bus", {mem_addr ^ mem_wdata, mem_wstrb}, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Signed/unsigned byte load, zero-wait memory
    do_access(1'b0, 0, 1'b0, 64'h8000_0005, 64'd0, 64'h0000_8000_0000_0000, 0, 1);
    do_access(1'b0, 0, 1'b1, 64'h8000_0005, 64'd0, 64'h0000_8000_0000_0000, 0, 1);
    // Half store into upper lanes
    do_access(1'b1, 1, 1'b0, 64'h8000_0006, 64'h1234, 64'hDEAD_BEEF_0BAD_F00D, 0, 1);
    // Back-pressure: ready held low for 5 cycles
    do_access(1'b1, 2, 1'b0, 64'h8000_0010, 64'hCAFE_F00D, 64'd0, 5, 1);
    // Ready and rvalid together
    do_access(1'b0, 3, 1'b0, 64'h8000_0020, 64'd0, 64'h8765_4321_0FED_CBA9, 0, 0);
    // Timeout: rvalid never comes
    do_access(1'b0, 3, 1'b0, 64'h8000_0028, 64'd0, 64'h1, 0, -1);
    // Misaligned word load
    do_access(1'b0, 2, 1'b0, 64'h8000_0002, 64'd0, 64'h1122_3344_5566_7788, 0, 1);

    // Reset while waiting for read data
    req_valid = 1'b1;  req_wen = 1'b0;  req_size = 2'd3;  req_addr = 64'h8000_0040;
    @(posedge clk); #1;
    req_valid = 1'b0;  mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    check_eq("wait_status", {busy, mem_valid, req_ready}, 3'b100);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check_eq("mid_reset", {req_ready, busy, mem_valid, resp_valid}, 4'b1000);
    mem_rvalid = 1'b1;  mem_rdata = 64'hFFFF_0000_FFFF_0000;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check_eq("late_rvalid", {resp_valid, req_ready, busy}, 3'b010);
      @(posedge clk); #1;
    end

    for (int t = 0; t < 80; t++) begin
      a = {32'h0, 32'h8000_0000 + ($urandom_range(0, 1023))};
      do_access(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                a, {$urandom, $urandom}, {$urandom, $urandom},
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
